// File: rtl/hier_collect_node5.sv
// ---------------------------------------------------------------------------
// hier_collect_node5
// Fan-in node of the hierarchy tree. It merges NUM_CH child packet streams
// into one upstream stream. Children are served round-robin. A granted child
// keeps the output until its last beat. The output beat is registered and
// tagged with the index of the child that produced it.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   per-child beat valid
//   in_ready   per-child beat accept (never depends on in_valid)
//   in_data    child payloads, child i at [i*DATA_W +: DATA_W]
//   in_last    per-child end-of-packet marker
//   out_valid  upstream beat valid (registered)
//   out_ready  upstream accept
//   out_data   upstream payload (registered)
//   out_last   upstream end-of-packet (registered)
//   out_src    child index of the current beat (registered)
//   busy       high while a child owns the output (registered)
// ---------------------------------------------------------------------------
module hier_collect_node5 #(
    parameter int unsigned NUM_CH = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SRC_W  = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          in_valid,
    output logic [NUM_CH-1:0]          in_ready,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    input  logic [NUM_CH-1:0]          in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_last,
    output logic [SRC_W-1:0]           out_src,
    output logic                       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [SRC_W-1:0]   grant_q, grant_d;
    logic [SRC_W-1:0]   last_grant_q, last_grant_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               out_last_q, out_last_d;
    logic [SRC_W-1:0]   out_src_q, out_src_d;
    logic               busy_q, busy_d;

    logic               arb_hit;
    logic [SRC_W-1:0]   arb_idx;
    logic               sel_valid;
    logic               sel_last;
    logic [DATA_W-1:0]  sel_data;
    logic               out_free;
    logic               accept;

    // Round-robin search starting one past the last served child, wrapping
    // modulo NUM_CH so non-existent channels are never considered.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            for (int unsigned j = 0; j < NUM_CH; j++) begin
                if (!arb_hit && in_valid[j] &&
                    j == (32'(last_grant_q) + k) % NUM_CH) begin
                    arb_hit = 1'b1;
                    arb_idx = SRC_W'(j);
                end
            end
        end
    end

    // Select the granted child's beat.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned j = 0; j < NUM_CH; j++) begin
            if (grant_q == SRC_W'(j)) begin
                sel_valid = in_valid[j];
                sel_last  = in_last[j];
                sel_data  = in_data[j*DATA_W +: DATA_W];
            end
        end
    end

    // The output register can take a beat when empty or draining this cycle.
    assign out_free = !out_valid_q || out_ready;

    // Only the granted child sees ready, and only while locked.
    always_comb begin
        in_ready = '0;
        if (state_q == LOCK) begin
            for (int unsigned j = 0; j < NUM_CH; j++) begin
                if (grant_q == SRC_W'(j)) begin
                    in_ready[j] = out_free;
                end
            end
        end
    end

    assign accept = (state_q == LOCK) && sel_valid && out_free;

    // Next-state and output-register logic.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        out_src_d    = out_src_q;

        // Upstream took the held beat; emptied unless refilled below.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (arb_hit) begin
                    grant_d = arb_idx;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = sel_data;
                    out_last_d  = sel_last;
                    out_src_d   = grant_q;
                    if (sel_last) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == LOCK);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= SRC_W'(NUM_CH - 1);
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            out_src_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            out_src_q    <= out_src_d;
            busy_q       <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_hier_collect_node5.sv
// ---------------------------------------------------------------------------
// tb_hier_collect_node5
// Directed bench for hier_collect_node5 (5 children, 32-bit data).
// Each child is a small packet source: base value, length, beats sent.
// Expected upstream beats are written out by hand at each step.
// ---------------------------------------------------------------------------
module tb_hier_collect_node5;

    logic         clk;
    logic         rst_n;
    logic [4:0]   in_valid;
    logic [4:0]   in_ready;
    logic [159:0] in_data;
    logic [4:0]   in_last;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic [2:0]   out_src;
    logic         busy;

    int total = 0;
    int bad   = 0;

    int base   [5];
    int len    [5];
    int sent   [5];
    bit active [5];

    hier_collect_node5 #(.NUM_CH(5), .DATA_W(32), .SRC_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive child i from its source state.
    task automatic apply(input int i);
        in_valid[i]            = active[i];
        in_data[i*32 +: 32]    = 32'(base[i] + sent[i]);
        in_last[i]             = active[i] && (sent[i] == len[i] - 1);
    endtask

    task automatic load(input int i, input int b, input int n);
        base[i]   = b;
        len[i]    = n;
        sent[i]   = 0;
        active[i] = 1'b1;
        apply(i);
    endtask

    // One clock: note handshakes before the edge, advance sources after it.
    task automatic cyc();
        logic [4:0] hs;
        @(negedge clk);
        hs = in_valid & in_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            if (hs[i]) begin
                sent[i]++;
                if (sent[i] == len[i]) active[i] = 1'b0;
                apply(i);
            end
        end
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] d, input logic [2:0] s, input logic l);
        chk({tag, ".valid"}, 64'(out_valid), 64'h1);
        chk({tag, ".data"},  64'(out_data),  64'(d));
        chk({tag, ".src"},   64'(out_src),   64'(s));
        chk({tag, ".last"},  64'(out_last),  64'(l));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".valid"}, 64'(out_valid), 64'h0);
        chk({tag, ".data"},  64'(out_data),  64'h0);
        chk({tag, ".last"},  64'(out_last),  64'h0);
        chk({tag, ".src"},   64'(out_src),   64'h0);
        chk({tag, ".busy"},  64'(busy),      64'h0);
        chk({tag, ".ready"}, 64'(in_ready),  64'h0);
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        for (int i = 0; i < 5; i++) begin
            base[i] = 0; len[i] = 1; sent[i] = 0; active[i] = 1'b0;
        end

        // Reset and idle
        cyc();
        cyc();
        chk_reset("rst");
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            cyc();
            chk("idle.valid", 64'(out_valid), 64'h0);
            chk("idle.busy",  64'(busy),      64'h0);
            chk("idle.ready", 64'(in_ready),  64'h0);
        end

        // Round-robin: every child holds a 1-beat packet, order 0..4
        for (int i = 0; i < 5; i++) load(i, 32'h10 + i, 1);
        cyc();
        chk("rr.arb.busy",  64'(busy),     64'h1);
        chk("rr.arb.ready", 64'(in_ready), 64'h01);
        chk("rr.arb.valid", 64'(out_valid), 64'h0);
        cyc();
        chk_beat("rr0", 32'h10, 3'd0, 1'b1);
        chk("rr0.ready", 64'(in_ready), 64'h0);
        for (int k = 1; k < 5; k++) begin
            cyc();
            chk("rr.gap.valid", 64'(out_valid), 64'h0);
            cyc();
            chk_beat("rrk", 32'(32'h10 + k), 3'(k), 1'b1);
        end
        // Refill ch0 and ch3: order 0 then 3
        load(0, 32'h20, 1);
        load(3, 32'h23, 1);
        cyc();
        cyc();
        chk_beat("rr2a", 32'h20, 3'd0, 1'b1);
        cyc();
        cyc();
        chk_beat("rr2b", 32'h23, 3'd3, 1'b1);

        // Single child ch2, three beats
        load(2, 32'hA0, 3);
        cyc();
        chk("one.arb.busy",  64'(busy),      64'h1);
        chk("one.arb.ready", 64'(in_ready),  64'h04);
        chk("one.arb.valid", 64'(out_valid), 64'h0);
        cyc();
        chk_beat("one0", 32'hA0, 3'd2, 1'b0);
        cyc();
        chk_beat("one1", 32'hA1, 3'd2, 1'b0);
        cyc();
        chk_beat("one2", 32'hA2, 3'd2, 1'b1);
        chk("one2.busy", 64'(busy), 64'h0);
        cyc();
        chk("one.end.valid", 64'(out_valid), 64'h0);
        chk("one.end.busy",  64'(busy),      64'h0);

        // Packet lock: ch0 requests while ch1 is mid-packet
        load(1, 32'h40, 4);
        cyc();
        chk("lock.arb.ready", 64'(in_ready), 64'h02);
        cyc();
        chk_beat("lock0", 32'h40, 3'd1, 1'b0);
        load(0, 32'h50, 1);
        cyc();
        chk_beat("lock1", 32'h41, 3'd1, 1'b0);
        chk("lock1.ready", 64'(in_ready), 64'h02);
        cyc();
        chk_beat("lock2", 32'h42, 3'd1, 1'b0);
        chk("lock2.ready", 64'(in_ready), 64'h02);
        cyc();
        chk_beat("lock3", 32'h43, 3'd1, 1'b1);
        cyc();
        chk("lock.gap.valid", 64'(out_valid), 64'h0);
        chk("lock.gap.ready", 64'(in_ready),  64'h01);
        cyc();
        chk_beat("lock.ch0", 32'h50, 3'd0, 1'b1);

        // Backpressure during a ch4 packet
        load(4, 32'h60, 4);
        cyc();
        cyc();
        chk_beat("bp0", 32'h60, 3'd4, 1'b0);
        cyc();
        chk_beat("bp1", 32'h61, 3'd4, 1'b0);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk_beat("bp.hold", 32'h61, 3'd4, 1'b0);
            chk("bp.hold.ready", 64'(in_ready), 64'h00);
        end
        out_ready = 1'b1;
        cyc();
        chk_beat("bp2", 32'h62, 3'd4, 1'b0);
        cyc();
        chk_beat("bp3", 32'h63, 3'd4, 1'b1);
        cyc();
        chk("bp.end.valid", 64'(out_valid), 64'h0);

        // Reset in the middle of a 5-beat ch3 packet
        load(3, 32'h70, 5);
        cyc();
        cyc();
        chk_beat("mr0", 32'h70, 3'd3, 1'b0);
        cyc();
        chk_beat("mr1", 32'h71, 3'd3, 1'b0);
        rst_n = 1'b0;
        active[3] = 1'b0;
        apply(3);
        #1;
        chk_reset("mr.low");
        cyc();
        cyc();
        chk_reset("mr.low2");
        rst_n = 1'b1;
        load(0, 32'h80, 1);
        load(3, 32'h90, 1);
        cyc();
        chk("mr.arb.ready", 64'(in_ready),  64'h01);
        chk("mr.arb.valid", 64'(out_valid), 64'h0);
        cyc();
        chk_beat("mr.ch0", 32'h80, 3'd0, 1'b1);
        cyc();
        chk("mr.gap.valid", 64'(out_valid), 64'h0);
        cyc();
        chk_beat("mr.ch3", 32'h90, 3'd3, 1'b1);
        cyc();
        chk("mr.end.valid", 64'(out_valid), 64'h0);
        chk("mr.end.busy",  64'(busy),      64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
